// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the two-requester data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_NIC = 1'b1
  } req_id_e;

  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_DATA_W    = 64;
  localparam int DEF_MAX_BURST = 8;

  // One entry of the in-flight load tracker: is it a load, and who owns it.
  typedef struct packed {
    logic    vld;
    req_id_e owner;
  } tag_t;

  localparam tag_t TAG_IDLE = '{vld: 1'b0, owner: REQ_CPU};

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-port signals of the data-memory arbiter.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              nic_req;
  logic              nic_we;
  logic [ADDR_W-1:0] nic_addr;
  logic [DATA_W-1:0] nic_wdata;
  logic              nic_lock;
  logic              nic_gnt;
  logic              nic_rvalid;
  logic [DATA_W-1:0] nic_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  nic_req, nic_we, nic_addr, nic_wdata, nic_lock,
    output nic_gnt, nic_rvalid, nic_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output nic_req, nic_we, nic_addr, nic_wdata, nic_lock,
    input  nic_gnt, nic_rvalid, nic_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arbiter_rr.sv
// Two-way round-robin grant with a bounded NIC lock burst; grants are
// combinational from the requests and the last-winner/burst state.
module rr_arbiter2
  import dmem_arb_pkg::*;
#(
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic cpu_req_i,
  input  logic nic_req_i,
  input  logic nic_lock_i,
  output logic cpu_gnt_o,
  output logic nic_gnt_o
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  req_id_e          last_q, last_d;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic             cpu_gnt_s, nic_gnt_s;

  // Grant decision; an exhausted burst hands the tie back to the CPU.
  always_comb begin
    cpu_gnt_s = 1'b0;
    nic_gnt_s = 1'b0;
    if (reset_i) begin
      cpu_gnt_s = 1'b0;
      nic_gnt_s = 1'b0;
    end else if (cpu_req_i && nic_req_i) begin
      if (burst_q == BURST_MAX) begin
        cpu_gnt_s = 1'b1;
      end else if ((last_q == REQ_NIC) && nic_lock_i) begin
        nic_gnt_s = 1'b1;
      end else if (last_q == REQ_NIC) begin
        cpu_gnt_s = 1'b1;
      end else begin
        nic_gnt_s = 1'b1;
      end
    end else if (cpu_req_i) begin
      cpu_gnt_s = 1'b1;
    end else if (nic_req_i) begin
      nic_gnt_s = 1'b1;
    end else begin
      cpu_gnt_s = 1'b0;
      nic_gnt_s = 1'b0;
    end
  end

  // Next last-winner and saturating burst count.
  always_comb begin
    last_d  = last_q;
    burst_d = burst_q;
    if (cpu_gnt_s) begin
      last_d  = REQ_CPU;
      burst_d = {CNT_W{1'b0}};
    end else if (nic_gnt_s) begin
      last_d = REQ_NIC;
      if (!nic_lock_i) begin
        burst_d = {CNT_W{1'b0}};
      end else if (burst_q == BURST_MAX) begin
        burst_d = burst_q;
      end else begin
        burst_d = burst_q + CNT_W'(1'b1);
      end
    end else begin
      last_d  = last_q;
      burst_d = burst_q;
    end
  end

  // Arbiter state; NIC as last winner so the first tie goes to the CPU.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_q  <= REQ_NIC;
      burst_q <= {CNT_W{1'b0}};
    end else begin
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end

  assign cpu_gnt_o = cpu_gnt_s;
  assign nic_gnt_o = nic_gnt_s;

endmodule

// File: rtl/dmem_arbiter.sv
// CPU/NIC arbiter for a single-port data memory: registered command stage
// plus a two-stage owner tag pipeline that routes load data back.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input logic          clk,
  input logic          reset,
  dmem_arbiter_if.slave bus
);

  logic              cpu_gnt_s, nic_gnt_s;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  tag_t              tag1_q, tag1_d;
  tag_t              tag2_q, tag2_d;

  rr_arbiter2 #(.MAX_BURST(MAX_BURST)) u_rr (
    .clk_i      (clk),
    .reset_i    (reset),
    .cpu_req_i  (bus.cpu_req),
    .nic_req_i  (bus.nic_req),
    .nic_lock_i (bus.nic_lock),
    .cpu_gnt_o  (cpu_gnt_s),
    .nic_gnt_o  (nic_gnt_s)
  );

  // Select the winner's command and tag it if it is a load.
  always_comb begin
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = {ADDR_W{1'b0}};
    mem_wdata_d = {DATA_W{1'b0}};
    tag1_d      = TAG_IDLE;
    if (cpu_gnt_s) begin
      mem_en_d     = 1'b1;
      mem_we_d     = bus.cpu_we;
      mem_addr_d   = bus.cpu_addr;
      mem_wdata_d  = bus.cpu_wdata;
      tag1_d.vld   = ~bus.cpu_we;
      tag1_d.owner = REQ_CPU;
    end else if (nic_gnt_s) begin
      mem_en_d     = 1'b1;
      mem_we_d     = bus.nic_we;
      mem_addr_d   = bus.nic_addr;
      mem_wdata_d  = bus.nic_wdata;
      tag1_d.vld   = ~bus.nic_we;
      tag1_d.owner = REQ_NIC;
    end else begin
      mem_en_d = 1'b0;
      tag1_d   = TAG_IDLE;
    end
    tag2_d = tag1_q;
  end

  // Command and tag registers; reset drops every in-flight load.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      tag1_q      <= TAG_IDLE;
      tag2_q      <= TAG_IDLE;
    end else begin
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag2_d;
    end
  end

  assign bus.cpu_gnt    = cpu_gnt_s;
  assign bus.nic_gnt    = nic_gnt_s;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.cpu_rvalid = tag2_q.vld && (tag2_q.owner == REQ_CPU);
  assign bus.nic_rvalid = tag2_q.vld && (tag2_q.owner == REQ_NIC);
  // Memory data is only forwarded to the owner of the returning load.
  assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_rdata : {DATA_W{1'b0}};
  assign bus.nic_rdata  = bus.nic_rvalid ? bus.mem_rdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench: directed scenarios plus a per-cycle scoreboard that
// models grants, memory commands and in-order load returns.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int MAXB = 8;

  logic clk = 1'b0;
  logic reset;
  int   pass_cnt = 0;
  int   chk_cnt  = 0;

  dmem_arbiter_if #(.ADDR_W(16), .DATA_W(64)) bus ();

  dmem_arbiter #(.ADDR_W(16), .DATA_W(64), .MAX_BURST(MAXB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory, read data one cycle after the command.
  logic [63:0] mem [256] = '{default: 64'd0};
  always @(posedge clk) begin
    if (bus.mem_en === 1'b1) begin
      if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem[bus.mem_addr[7:0]];
    end
  end

  typedef struct {
    int          due;
    logic        owner;
    logic [63:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] shadow [256] = '{default: 64'd0};
  int          cyc_n = 0, xfer_cnt = 0, men_cnt = 0, m_burst = 0;
  logic        m_last = 1'b1;
  logic        pred_valid = 1'b0, p_full = 1'b0, p_en = 1'b0, p_we = 1'b0;
  logic [15:0] p_addr = 16'd0;
  logic [63:0] p_wdata = 64'd0;

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin : monitor
    logic        ecg, eng, ev_c, ev_n, we;
    logic [15:0] addr;
    logic [63:0] ed, wd;
    cyc_n = cyc_n + 1;
    if (pred_valid) begin
      chk_cnt++;
      if (bus.mem_en !== p_en ||
          (p_full && {bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {p_we, p_addr, p_wdata}))
        $display("FAIL mem_cmd cyc %0d: got en=%b we=%b addr=%h wd=%h expected en=%b we=%b addr=%h wd=%h",
                 cyc_n, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, p_en, p_we, p_addr, p_wdata);
      else pass_cnt++;
    end
    ev_c = 1'b0; ev_n = 1'b0; ed = 64'd0;
    if (sb.size() > 0 && sb[0].due == cyc_n) begin
      ev_c = ~sb[0].owner;
      ev_n = sb[0].owner;
      ed   = sb[0].data;
      void'(sb.pop_front());
    end
    chk_cnt++;
    if (bus.cpu_rvalid !== ev_c || bus.nic_rvalid !== ev_n ||
        bus.cpu_rdata !== (ev_c ? ed : 64'd0) || bus.nic_rdata !== (ev_n ? ed : 64'd0))
      $display("FAIL rvalid cyc %0d: got cv=%b nv=%b cd=%h nd=%h expected cv=%b nv=%b data=%h",
               cyc_n, bus.cpu_rvalid, bus.nic_rvalid, bus.cpu_rdata, bus.nic_rdata, ev_c, ev_n, ed);
    else pass_cnt++;
    ecg = 1'b0; eng = 1'b0;
    if (reset) begin
      ecg = 1'b0;
    end else if (bus.cpu_req && bus.nic_req) begin
      if (m_burst == MAXB)              ecg = 1'b1;
      else if (bus.nic_lock && m_last)  eng = 1'b1;
      else if (m_last)                  ecg = 1'b1;
      else                              eng = 1'b1;
    end else begin
      ecg = bus.cpu_req;
      eng = bus.nic_req;
    end
    chk_cnt++;
    if ({bus.cpu_gnt, bus.nic_gnt} !== {ecg, eng})
      $display("FAIL grant cyc %0d: got %b%b expected %b%b", cyc_n, bus.cpu_gnt, bus.nic_gnt, ecg, eng);
    else pass_cnt++;
    if (reset) begin
      sb.delete();
      m_last = 1'b1; m_burst = 0;
      p_en = 1'b0; p_we = 1'b0; p_addr = 16'd0; p_wdata = 64'd0; p_full = 1'b1;
    end else if (ecg || eng) begin
      xfer_cnt++;
      we   = eng ? bus.nic_we    : bus.cpu_we;
      addr = eng ? bus.nic_addr  : bus.cpu_addr;
      wd   = eng ? bus.nic_wdata : bus.cpu_wdata;
      p_en = 1'b1; p_we = we; p_addr = addr; p_wdata = wd; p_full = 1'b1;
      if (we) shadow[addr[7:0]] = wd;
      else    sb.push_back('{due: cyc_n + 2, owner: eng, data: shadow[addr[7:0]]});
      if (ecg) m_burst = 0;
      else if (!bus.nic_lock) m_burst = 0;
      else if (m_burst < MAXB) m_burst = m_burst + 1;
      m_last = eng;
    end else begin
      p_en = 1'b0; p_full = 1'b0;
    end
    if (bus.mem_en === 1'b1) men_cnt++;
    pred_valid = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 16'd0; bus.cpu_wdata = 64'd0;
    bus.nic_req = 1'b0; bus.nic_we = 1'b0; bus.nic_addr = 16'd0; bus.nic_wdata = 64'd0;
    bus.nic_lock = 1'b0;
  endtask

  task automatic drive_cpu(input logic we, input logic [15:0] addr, input logic [63:0] wd);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
  endtask

  task automatic drive_nic(input logic we, input logic [15:0] addr, input logic [63:0] wd, input logic lock);
    bus.nic_req = 1'b1; bus.nic_we = we; bus.nic_addr = addr; bus.nic_wdata = wd; bus.nic_lock = lock;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_cpu(1'b0, 16'h0001, 64'd0);
    drive_nic(1'b0, 16'h0002, 64'd0, 1'b0);
    #1;
    chk_cnt++;
    if ({bus.cpu_gnt, bus.nic_gnt} !== 2'b00)
      $display("FAIL reset_gnt: got %b%b expected 00", bus.cpu_gnt, bus.nic_gnt);
    else pass_cnt++;
    tick();
    reset = 1'b0;
    idle();
    #1;
    chk_cnt++;
    if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.cpu_rvalid, bus.nic_rvalid} !== 84'd0)
      $display("FAIL reset_outputs: got en=%b we=%b addr=%h wd=%h cv=%b nv=%b expected all 0",
               bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.cpu_rvalid, bus.nic_rvalid);
    else pass_cnt++;
  endtask

  task automatic test_single_load();
    tick(); idle(); drive_nic(1'b1, 16'h0010, 64'hDEADBEEF00000001, 1'b0);
    tick(); idle();
    tick(); drive_cpu(1'b0, 16'h0010, 64'd0); #1;
    chk_cnt++;
    if ({bus.cpu_gnt, bus.nic_gnt} !== 2'b10)
      $display("FAIL single_gnt: got %b%b expected 10", bus.cpu_gnt, bus.nic_gnt);
    else pass_cnt++;
    tick(); idle(); #1;
    chk_cnt++;
    if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 16'h0010})
      $display("FAIL single_cmd: got en=%b we=%b addr=%h expected en=1 we=0 addr=0010",
               bus.mem_en, bus.mem_we, bus.mem_addr);
    else pass_cnt++;
    tick(); #1;
    chk_cnt++;
    if ({bus.cpu_rvalid, bus.nic_rvalid, bus.cpu_rdata} !== {2'b10, 64'hDEADBEEF00000001})
      $display("FAIL single_rdata: got cv=%b nv=%b data=%h expected cv=1 nv=0 data=deadbeef00000001",
               bus.cpu_rvalid, bus.nic_rvalid, bus.cpu_rdata);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    tick(); idle(); reset = 1'b1;
    tick(); reset = 1'b0;
    drive_cpu(1'b0, 16'h0001, 64'd0);
    drive_nic(1'b0, 16'h0002, 64'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk_cnt++;
      if ({bus.cpu_gnt, bus.nic_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
        $display("FAIL rr_gnt[%0d]: got %b%b expected %s", i, bus.cpu_gnt, bus.nic_gnt, (i % 2 == 0) ? "10" : "01");
      else pass_cnt++;
      if (i >= 2) begin
        chk_cnt++;
        if ({bus.cpu_rvalid, bus.nic_rvalid} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
          $display("FAIL rr_rvalid[%0d]: got %b%b", i, bus.cpu_rvalid, bus.nic_rvalid);
        else pass_cnt++;
      end
      tick();
    end
    idle();
    repeat (3) tick();
  endtask

  task automatic test_burst_lock();
    idle(); drive_cpu(1'b0, 16'h0003, 64'd0);
    tick();
    drive_nic(1'b0, 16'h0004, 64'd0, 1'b1);
    for (int i = 0; i < 18; i++) begin
      #1;
      chk_cnt++;
      if ({bus.cpu_gnt, bus.nic_gnt} !== ((i % 9 == 8) ? 2'b10 : 2'b01))
        $display("FAIL burst_gnt[%0d]: got %b%b expected %s", i, bus.cpu_gnt, bus.nic_gnt, (i % 9 == 8) ? "10" : "01");
      else pass_cnt++;
      tick();
    end
    idle();
    repeat (3) tick();
  endtask

  task automatic test_store_forward();
    idle(); drive_nic(1'b1, 16'h0020, 64'h0000000000001234, 1'b0); #1;
    chk_cnt++;
    if (bus.nic_gnt !== 1'b1) $display("FAIL fwd_store_gnt: got %b expected 1", bus.nic_gnt);
    else pass_cnt++;
    tick(); idle(); drive_cpu(1'b0, 16'h0020, 64'd0);
    tick(); idle(); #1;
    chk_cnt++;
    if (bus.nic_rvalid !== 1'b0) $display("FAIL fwd_no_nic_rvalid: got %b expected 0", bus.nic_rvalid);
    else pass_cnt++;
    tick(); #1;
    chk_cnt++;
    if ({bus.cpu_rvalid, bus.nic_rvalid, bus.cpu_rdata} !== {2'b10, 64'h0000000000001234})
      $display("FAIL fwd_rdata: got cv=%b nv=%b data=%h expected cv=1 nv=0 data=1234",
               bus.cpu_rvalid, bus.nic_rvalid, bus.cpu_rdata);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_midflight();
    idle(); drive_cpu(1'b0, 16'h0010, 64'd0);
    tick(); reset = 1'b1; #1;
    chk_cnt++;
    if ({bus.cpu_gnt, bus.nic_gnt} !== 2'b00)
      $display("FAIL midrst_gnt: got %b%b expected 00", bus.cpu_gnt, bus.nic_gnt);
    else pass_cnt++;
    tick(); reset = 1'b0; idle(); #1;
    chk_cnt++;
    if ({bus.cpu_rvalid, bus.nic_rvalid, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.cpu_rdata} !== 148'd0)
      $display("FAIL midrst_outputs: got cv=%b nv=%b en=%b we=%b addr=%h expected all 0",
               bus.cpu_rvalid, bus.nic_rvalid, bus.mem_en, bus.mem_we, bus.mem_addr);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      idle();
      if ($urandom_range(0, 9) < 7)
        drive_cpu(1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), {$urandom, $urandom});
      if ($urandom_range(0, 9) < 7)
        drive_nic(1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), {$urandom, $urandom},
                  1'($urandom_range(0, 3) != 0));
      tick();
    end
    idle();
    repeat (4) tick();
    chk_cnt++;
    if (sb.size() != 0) $display("FAIL rand_drain: got %0d loads pending expected 0", sb.size());
    else pass_cnt++;
    chk_cnt++;
    if (men_cnt != xfer_cnt) $display("FAIL rand_mem_en_count: got %0d expected %0d", men_cnt, xfer_cnt);
    else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) tick();
    test_reset();
    test_single_load();
    test_round_robin();
    test_burst_lock();
    test_store_forward();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, SHALL set the data-memory word-address width.
REQ-002 Parameter DATA_W, default 64, SHALL set the data-memory word width.
REQ-003 Parameter MAX_BURST, default 8, SHALL set the maximum consecutive locked NIC grants while the CPU waits.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  in  1  SHALL be a synchronous, active-high reset.
REQ-006 cpu_req  in  1  CPU access request; cpu_we  in  1  1=store, 0=load; cpu_addr  in  ADDR_W; cpu_wdata  in  DATA_W.
REQ-007 cpu_gnt  out  1  CPU request accepted this cycle; cpu_rvalid  out  1  load data valid; cpu_rdata  out  DATA_W.
REQ-008 nic_req, nic_we, nic_addr, nic_wdata SHALL mirror the CPU inputs for the NIC requester.
REQ-009 nic_lock  in  1  NIC requests back-to-back ownership (burst).
REQ-010 nic_gnt, nic_rvalid, nic_rdata SHALL mirror the CPU outputs for the NIC.
REQ-011 mem_en  out  1; mem_we  out  1; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W: single-port memory command.
REQ-012 mem_rdata  in  DATA_W: memory read data, valid the cycle after a mem_en=1, mem_we=0 command.

Function
REQ-013 A transfer SHALL occur in cycle T when req and gnt are both 1 for one requester; gnt is combinational from req and state.
REQ-014 At most one of cpu_gnt/nic_gnt SHALL be 1 in any cycle; gnt SHALL be 0 whenever its req is 0.
REQ-015 Single requester active: it SHALL be granted that cycle (no idle bubble).
REQ-016 Both active, no lock: grant SHALL go to the requester that did not win the last transfer (round-robin).
REQ-017 Both active, nic_lock=1, last winner NIC, burst_cnt < MAX_BURST: NIC SHALL be granted.
REQ-018 burst_cnt SHALL increment on each NIC transfer with nic_lock=1 and clear on any CPU transfer or any NIC transfer with nic_lock=0.
REQ-019 burst_cnt = MAX_BURST with cpu_req=1: CPU SHALL be granted regardless of nic_lock.
REQ-020 burst_cnt SHALL saturate at MAX_BURST.
REQ-021 Transfer in cycle T SHALL drive mem_en=1 and the registered mem_we/mem_addr/mem_wdata in T+1; otherwise mem_en=0 in T+1.
REQ-022 Load transfer in T SHALL assert the owner's rvalid in T+2 with rdata = mem_rdata; the other rvalid SHALL be 0.
REQ-023 Stores SHALL produce no rvalid.
REQ-024 A 2-stage owner/is-load tag pipeline SHALL track in-flight loads; back-to-back loads SHALL return in grant order, one per cycle.
REQ-025 cpu_rdata and nic_rdata SHALL carry mem_rdata when their rvalid=1 and 0 otherwise.
REQ-026 Sustained throughput SHALL be one transfer per cycle.

Reset
REQ-027 While reset=1: cpu_gnt, nic_gnt = 0; requests ignored.
REQ-028 Cycle after reset: mem_en, mem_we = 0; mem_addr, mem_wdata = 0; cpu_rvalid, nic_rvalid = 0; burst_cnt = 0.
REQ-029 Last-winner register SHALL reset to NIC so the first tie goes to the CPU.
REQ-030 Reset mid-operation SHALL discard all in-flight loads: no rvalid for transfers granted before reset.

Structure
REQ-031 Shared package dmem_arb_pkg SHALL hold requester-id constants (REQ_CPU=0, REQ_NIC=1) and default ADDR_W/DATA_W/MAX_BURST.
REQ-032 Grant logic (round-robin pointer, lock, burst counter) SHALL be one sub-module rr_arbiter2; command registers and tag pipeline stay in dmem_arbiter.

Verification
REQ-033 Only cpu_req=1, load, addr 0x0010, mem holds 0xDEADBEEF00000001 -> cpu_gnt in T, mem_en/addr 0x0010 in T+1, cpu_rvalid with that data in T+2.
REQ-034 Both requesting loads continuously, nic_lock=0 -> grants alternate CPU,NIC,CPU,NIC starting with CPU; rvalids alternate two cycles later.
REQ-035 nic_lock=1, NIC and CPU requesting continuously -> after one CPU win, exactly 8 NIC grants, then 1 CPU grant, repeat.
REQ-036 NIC store addr 0x0020 data 0x1234 in T, CPU load 0x0020 in T+1 -> CPU rdata = 0x1234 in T+3, no nic_rvalid.
REQ-037 Load granted in T, reset=1 in T+1 -> no rvalid in T+2; all outputs at reset values.
REQ-038 Continuous random traffic -> never both gnts, every load returns exactly once in order, mem_en count equals transfer count.
